uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter. It accepts bytes from fabric logic through a write strobe into a small FIFO and serializes them LSB-first on `tx` at a baud rate derived from the system clock. It is the transmit-side companion to the receive path that decodes single-byte LED commands. It carries status and echo traffic back to the host without the producer having to pace writes to the line rate.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO fed by a write strobe,
// drained LSB-first onto tx at CLOCK_FREQ_HZ / BAUD_RATE clocks per bit.
//
// Handshake: wr_en has no ready. A byte is taken on any rising edge where
// wr_en = 1 and full = 0. If full = 1, the byte is dropped and the sticky
// overflow flag is set. The FSM pops the FIFO internally whenever empty = 0,
// either while idle or on the last stop-bit cycle.
module uart_tx_fifo #(
  parameter int CLOCK_FREQ_HZ = 40000000,
  parameter int BAUD_RATE     = 4000000,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        tx,
  output logic [1:0]                  state_dbg
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  // Reject parameter sets the baud counter or pointer wrap cannot support
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLOCK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            wr_acc;
  logic            pop;
  logic            baud_last;

  assign wr_acc    = wr_en && !full_q;
  assign baud_last = (baud_q == BAUD_LAST);

  // FIFO bookkeeping: pointers, occupancy and flags for the next cycle
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_q);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !pop)      count_d = count_q + CW'(1);
    else if (!wr_acc && pop) count_d = count_q - CW'(1);
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // Frame sequencer: next state, baud/bit counters, shift register and pop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty_q) begin
            // Back-to-back: next start bit follows the stop bit directly
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the coming cycle, decoded from the next state so tx is a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Control and status registers; reset discards FIFO contents and idles the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) || !empty_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default instance checked cycle by cycle against a
// frame-position model, plus a serial decoder feeding a byte scoreboard;
// a second instance covers the 104 clocks-per-bit variant.
module tb_uart_tx_fifo;

  localparam int C     = 10;
  localparam int DEPTH = 16;
  localparam int C2    = 104;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, overflow, tx;
  logic [4:0] count;
  logic [1:0] state_dbg;

  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       full2, empty2, busy2, overflow2, tx2;
  logic [4:0] count2;
  logic [1:0] state_dbg2;

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .overflow(overflow), .tx(tx), .state_dbg(state_dbg)
  );

  uart_tx_fifo #(.CLOCK_FREQ_HZ(12000000), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dut_slow (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .count(count2), .busy(busy2),
    .overflow(overflow2), .tx(tx2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];   // bytes accepted, awaiting decode from the line
  logic [7:0] m_q[$];     // model FIFO contents
  bit         m_active;
  int         m_pos;      // cycle index within the current 10*C frame
  logic [7:0] m_cur;
  bit         m_ovf;

  bit         rx_busy;
  int         rx_t;
  logic [7:0] rx_byte;
  int         rx_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    m_q.delete();
    exp_q.delete();
    m_active = 0;
    m_pos    = 0;
    m_cur    = 8'h00;
    m_ovf    = 0;
    rx_busy  = 0;
    rx_t     = 0;
  endtask

  // One rising edge: a frame occupies 10*C cycles; a new one starts when the
  // FIFO holds a byte and the line is idle or on the frame's last cycle.
  task automatic model_edge();
    bit full_pre;
    bit do_pop;
    full_pre = (m_q.size() == DEPTH);
    do_pop   = (m_q.size() != 0) && (!m_active || m_pos == 10*C - 1);
    if (m_active) begin
      m_pos++;
      if (m_pos == 10*C) m_active = 0;
    end
    if (do_pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_pos    = 0;
    end
    if (wr_en) begin
      if (full_pre) m_ovf = 1;
      else begin
        m_q.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
  endtask

  function automatic logic model_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  // Independent line decoder: samples mid-bit and scores bytes against exp_q
  task automatic decode();
    if (rx_busy) begin
      rx_t++;
      if ((rx_t % C) == C/2 && rx_t >= C && rx_t < 9*C) rx_byte[(rx_t / C) - 1] = tx;
      if (rx_t == 9*C + C/2) begin
        check("rx_stop_bit", tx, 1);
        check("rx_byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
        rx_cnt++;
      end
      if (rx_t == 10*C - 1) rx_busy = 0;
    end else if (tx == 1'b0) begin
      rx_busy = 1;
      rx_t    = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_edge();
    @(negedge clk);
    check("tx", tx, model_tx());
    check("count", count, m_q.size());
    check("full", full, m_q.size() == DEPTH);
    check("empty", empty, m_q.size() == 0);
    check("busy", busy, m_active || (m_q.size() != 0));
    check("overflow", overflow, m_ovf);
    decode();
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int max_cycles, output int n);
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_fall(input int max_cycles, output int n);
    n = 1;
    while (tx && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, t, base, maxc, i, guard;
    logic e;
    @(negedge clk);
    apply_reset();
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    check("rst_slow_tx", tx2, 1);
    check("rst_slow_empty", empty2, 1);
    check("rst_slow_full", full2, 0);
    check("rst_slow_count", count2, 0);
    check("rst_slow_state", state_dbg2, 0);

    // Single byte: start bit at cycle 2, busy drops at cycle 102
    write_byte(8'h31);
    wait_fall(10, t);
    check("single_fall_cycle", t, 2);
    wait_idle(500, n);
    check("single_busy_end", t + n, 102);
    check("single_rx_count", rx_cnt, 1);

    // Back-to-back: four contiguous frames
    base = rx_cnt;
    write_byte(8'h31); write_byte(8'h32); write_byte(8'h33); write_byte(8'h34);
    wait_idle(1000, n);
    check("b2b_busy_end", n + 4, 402);
    check("b2b_rx_count", rx_cnt - base, 4);

    // Fill / overflow while a frame holds the transmitter busy
    base = rx_cnt;
    write_byte(8'($urandom_range(0, 255)));
    repeat (3) tick();
    for (int k = 0; k < DEPTH + 2; k++) write_byte(8'($urandom_range(0, 255)));
    check("fill_full", full, 1);
    check("fill_overflow", overflow, 1);
    wait_idle(3000, n);
    check("fill_rx_count", rx_cnt - base, DEPTH + 1);
    check("fill_dropped_absent", exp_q.size(), 0);

    // Pointer wrap: 48 incrementing bytes, written only while not full
    apply_reset();
    base = rx_cnt; maxc = 0; i = 0; guard = 0;
    while (i < 3*DEPTH && guard < 20000) begin
      if (!full) begin
        write_byte(8'(i));
        i++;
      end else tick();
      if (int'(count) > maxc) maxc = int'(count);
      guard++;
    end
    check("wrap_all_written", i, 3*DEPTH);
    wait_idle(6000, n);
    check("wrap_rx_count", rx_cnt - base, 3*DEPTH);
    check("wrap_max_count_ok", maxc <= DEPTH, 1);
    check("wrap_overflow", overflow, 0);

    // Random traffic, dense enough to overrun the FIFO at times
    for (int k = 0; k < 600; k++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    wr_en = 1'b0;
    wait_idle(5000, n);
    check("rand_drained", exp_q.size(), 0);

    // Reset during data bit 3 with two bytes queued
    apply_reset();
    write_byte(8'hC3); write_byte(8'h5A); write_byte(8'h0F);
    guard = 0;
    while (!(m_active && m_pos == 4*C + 3) && guard < 200) begin
      tick();
      guard++;
    end
    check("rst_mid_reached", m_active && m_pos == 4*C + 3, 1);
    check("rst_mid_tx_low_bit", tx, 0);
    #2 rst = 1'b1;
    #1 check("rst_mid_tx_async", tx, 1);
    model_clear();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_mid_empty", empty, 1);
    check("rst_mid_count", count, 0);
    base = rx_cnt;
    repeat (200) tick();
    check("rst_mid_no_frames", rx_cnt - base, 0);
    write_byte(8'h55);
    wait_fall(10, t);
    check("rst_mid_new_fall", t, 2);
    wait_idle(500, n);
    check("rst_mid_new_rx", rx_cnt - base, 1);
    check("rst_mid_drained", exp_q.size(), 0);

    // Slow instance: 104 clocks per bit, frame of 1040 cycles
    wr_en2   = 1'b1;
    wr_data2 = 8'hA5;
    tick();
    wr_en2   = 1'b0;
    for (int s = 1; s <= 1045; s++) begin
      int p;
      int b;
      logic [7:0] v;
      v = 8'hA5;
      p = s - 2;
      if (p < 0 || p >= 10*C2) e = 1'b1;
      else begin
        b = p / C2;
        if (b == 0) e = 1'b0;
        else if (b <= 8) e = v[b-1];
        else e = 1'b1;
      end
      check("slow_tx", tx2, e);
      if (s == 1041) check("slow_busy_last", busy2, 1);
      if (s == 1042) check("slow_busy_fall", busy2, 0);
      tick();
    end
    check("slow_overflow", overflow2, 0);
    check("slow_empty", empty2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
